handshake_packer: RTL

Valid/ready width upsizer placed directly downstream of the single-beat handshake register stage. It collects RATIO consecutive WIDTH-bit beats and packs them into one WIDTH*RATIO-bit word. A beat flagged last closes the word early, producing a partial word with a byte-lane-style keep mask. The packed word is held in a registered output slot that the wide-side consumer drains with its own valid/ready handshake.

---
 rtl/handshake_packer.sv | 80 ++++++++
 1 files changed

// File: rtl/handshake_packer.sv
// Valid/ready width upsizer: packs RATIO narrow beats into one wide word,
// closing early on last_i with a contiguous keep mask.
module handshake_packer #(
  parameter int WIDTH = 32,
  parameter int RATIO = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   last_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [WIDTH*RATIO-1:0] data_o,
  output logic [RATIO-1:0]       keep_o,
  output logic                   last_o
);

  localparam int CW = $clog2(RATIO);

  logic [CW-1:0]                cnt;
  logic [RATIO-2:0][WIDTH-1:0]  acc;
  logic [RATIO-1:0][WIDTH-1:0]  word_r;
  logic [RATIO-1:0][WIDTH-1:0]  word_next;
  logic [RATIO-1:0]             keep_next;
  logic                         accept;
  logic                         drain;
  logic                         complete;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. Valid never depends on ready; ready_o depends only on the
  // output slot (free, or being drained this cycle), never on valid_i/last_i.
  assign ready_o  = !valid_o || ready_i;
  assign accept   = valid_i && ready_o;
  assign drain    = valid_o && ready_i;
  assign complete = accept && (last_i || cnt == CW'(RATIO - 1));
  assign data_o   = word_r;

  // Accumulator slots at or above cnt are always zero, so only slots below
  // cnt are copied and everything above the current beat stays zero.
  always_comb begin
    word_next = '0;
    keep_next = '0;
    for (int k = 0; k < RATIO - 1; k++) begin
      if (CW'(k) < cnt) word_next[k] = acc[k];
    end
    for (int k = 0; k < RATIO; k++) begin
      if (CW'(k) == cnt) word_next[k] = data_i;
      keep_next[k] = (CW'(k) <= cnt);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      valid_o <= 1'b0;
      word_r  <= '0;
      keep_o  <= '0;
      last_o  <= 1'b0;
    end else begin
      if (drain) valid_o <= 1'b0;
      if (complete) begin
        valid_o <= 1'b1;
        word_r  <= word_next;
        keep_o  <= keep_next;
        last_o  <= last_i;
        cnt     <= '0;
        acc     <= '0;
      end else if (accept) begin
        for (int k = 0; k < RATIO - 1; k++) begin
          if (CW'(k) == cnt) acc[k] <= data_i;
        end
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule
